// File: rtl/leaf_output_arbiter.sv
// leaf_output_arbiter: round-robin burst arbiter sharing one registered leaf link among NUM_PORTS output ports.
//   clk, reset           : clock, synchronous active-high reset
//   arb_en, out_ready    : both must be high for any grant
//   port_ready           : per-port data and credit available
//   port_packets         : flattened internal_out of every port, port i at [i*PACKET_BITS +: PACKET_BITS]
//   rd_en_sel            : one-hot (or zero) read select, combinational
//   dout_leaf, vld_out   : registered link packet and its valid flag
//   grant_idx            : port that produced the current dout_leaf
//   proto_err            : sticky, a granted port returned a packet with valid bit 0
module leaf_output_arbiter #(
   parameter int NUM_PORTS   = 8,
   parameter int PACKET_BITS = 97,
   parameter int MAX_BURST   = 4
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             arb_en,
   input  logic [NUM_PORTS-1:0]             port_ready,
   input  logic [NUM_PORTS*PACKET_BITS-1:0] port_packets,
   input  logic                             out_ready,
   output logic [NUM_PORTS-1:0]             rd_en_sel,
   output logic [PACKET_BITS-1:0]           dout_leaf,
   output logic                             vld_out,
   output logic [$clog2(NUM_PORTS)-1:0]     grant_idx,
   output logic                             proto_err
);
   localparam int IW = $clog2(NUM_PORTS);
   localparam int CW = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                 state, state_nx;
   logic [IW-1:0]          owner, owner_nx, rr_ptr, rr_nx, winner, gidx, s1;
   logic [CW-1:0]          burst_cnt, cnt_nx;
   logic                   has_win, can_grant, grant, g1;
   logic [PACKET_BITS-1:0] sel_pkt;

   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] a, input int b);
      int s;
      s = int'(a) + b;
      if (s >= NUM_PORTS) s -= NUM_PORTS;
      return IW'(s);
   endfunction

   assign can_grant = arb_en && out_ready;
   assign sel_pkt   = port_packets[s1*PACKET_BITS +: PACKET_BITS];
   assign rd_en_sel = (grant && !reset) ? NUM_PORTS'(1) << gidx : '0;

   // Scan downward so the ready port closest to rr_ptr is the last (winning) assignment.
   always_comb begin
      winner  = '0;
      has_win = 1'b0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         if (port_ready[wrap_add(rr_ptr, k)]) begin
            winner  = wrap_add(rr_ptr, k);
            has_win = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      owner_nx = owner;
      cnt_nx   = burst_cnt;
      rr_nx    = rr_ptr;
      grant    = 1'b0;
      gidx     = owner;
      if (state == IDLE) begin
         if (can_grant && has_win) begin
            grant    = 1'b1;
            gidx     = winner;
            owner_nx = winner;
            cnt_nx   = CW'(1);
            if (MAX_BURST == 1) rr_nx = wrap_add(winner, 1);
            else state_nx = BURST;
         end
      end else if (!port_ready[owner]) begin
         // Owner ran dry: give up the burst without granting this cycle.
         state_nx = IDLE;
         rr_nx    = wrap_add(owner, 1);
      end else if (can_grant) begin
         grant  = 1'b1;
         cnt_nx = burst_cnt + CW'(1);
         if (cnt_nx == CW'(MAX_BURST)) begin
            state_nx = IDLE;
            rr_nx    = wrap_add(owner, 1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         owner     <= '0;
         burst_cnt <= '0;
         rr_ptr    <= '0;
         g1        <= 1'b0;
         s1        <= '0;
         dout_leaf <= '0;
         vld_out   <= 1'b0;
         grant_idx <= '0;
         proto_err <= 1'b0;
      end else begin
         state     <= state_nx;
         owner     <= owner_nx;
         burst_cnt <= cnt_nx;
         rr_ptr    <= rr_nx;
         g1        <= grant;
         s1        <= gidx;
         dout_leaf <= g1 ? sel_pkt : '0;
         vld_out   <= g1;
         if (g1) grant_idx <= s1;
         if (g1 && !sel_pkt[PACKET_BITS-1]) proto_err <= 1'b1;
      end
   end
endmodule

// File: doc/leaf_output_arbiter.md
# leaf_output_arbiter

Round-robin burst arbiter that shares one leaf-to-BFT packet link among `NUM_PORTS` output ports of a leaf interface. It issues one-hot read selects into the ports' `rd_en_sel` inputs and muxes the selected port's `internal_out` packet onto a single registered link output. It sits between the array of output ports and the tree switch's leaf input.

## Interface
Parameters:
- `NUM_PORTS`, 8: number of output ports arbitrated (2..16).
- `PACKET_BITS`, 97: packet width; bit `PACKET_BITS-1` is the packet valid bit.
- `MAX_BURST`, 4: maximum consecutive grants to one port before rotating (≥1).

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: reset, synchronous and active-high.
- `arb_en`, in, 1: global enable; 0 blocks new grants.
- `port_ready`, in, `NUM_PORTS`: port i has data and credit (`!empty && FreeCnt>0`).
- `port_packets`, in, `NUM_PORTS*PACKET_BITS`: flattened `internal_out` of each port; port i occupies slice `[i*PACKET_BITS +: PACKET_BITS]`.
- `out_ready`, in, 1: the link can absorb a packet issued this cycle.
- `rd_en_sel`, out, `NUM_PORTS`: one-hot or zero read select, combinational from state and inputs.
- `dout_leaf`, out, `PACKET_BITS`: registered packet to the link.
- `vld_out`, out, 1: `dout_leaf` holds a packet.
- `grant_idx`, out, `$clog2(NUM_PORTS)`: index of the port that produced the current `dout_leaf`.
- `proto_err`, out, 1: sticky; a granted port returned a packet with valid bit 0.

## Operation
- State: `IDLE` or `BURST`. Registers: `owner`, `burst_cnt` (`$clog2(MAX_BURST+1)` bits), `rr_ptr`.
- A grant is possible only when `arb_en && out_ready`.
- **IDLE:**
  - Winner is the first i with `port_ready[i]`, searching from `rr_ptr` upward with wrap modulo `NUM_PORTS`.
  - If a grant is possible and a winner exists: assert `rd_en_sel[winner]`, set `owner=winner`, `burst_cnt=1`.
  - If `MAX_BURST==1`: stay in IDLE and set `rr_ptr=(winner+1)%NUM_PORTS`. Otherwise go to BURST.
- **BURST:**
  - If `!port_ready[owner]`: no grant this cycle, go to IDLE, `rr_ptr=(owner+1)%NUM_PORTS`.
  - Else if a grant is possible: assert `rd_en_sel[owner]` and increment `burst_cnt`. If the new count equals `MAX_BURST`, go to IDLE with `rr_ptr=owner+1` (mod).
  - Else (`out_ready` or `arb_en` low): hold state, no grant. The burst count is preserved.
- At most one bit of `rd_en_sel` is high in any cycle.
- **Output pipe:**
  - Stage 1 registers `g1` (a grant occurred) and `s1` (the granted index).
  - Stage 2:
    - If `g1`: `dout_leaf <= port_packets[s1]`, `vld_out <= 1`, `grant_idx <= s1`.
    - Else: `dout_leaf <= 0`, `vld_out <= 0`, and `grant_idx` holds.
  - If `g1` and the selected packet's bit `PACKET_BITS-1` is 0, set `proto_err` (cleared only by reset).
- **Reset:** state=IDLE, `owner=0`, `burst_cnt=0`, `rr_ptr=0`, `g1=0`, `dout_leaf=0`, `vld_out=0`, `grant_idx=0`, `proto_err=0`. `rd_en_sel` is 0 while `reset` is high.
- **Reset mid-burst:** packets already granted but not yet registered are dropped. Their credits are re-initialised by the ports' own reset.

## Timing
- Grant at cycle T (`rd_en_sel` high). The port's `internal_out` is valid at T+1. `dout_leaf`/`vld_out` are valid at T+2. Fixed 2-cycle latency.
- Back-to-back grants give one packet per cycle on `dout_leaf`.
- `out_ready` is sampled only at grant time. The link must absorb up to 2 in-flight packets after `out_ready` falls.
- Owner exhaustion in BURST costs one idle cycle before the next port is granted. A MAX_BURST rotation costs no bubble only if the cycle after rotation's IDLE finds a ready port (IDLE grants in the same cycle).
- `port_ready` changes take effect combinationally in the same cycle. The ports must not deassert `ready` and then read on the same select.

## Test plan
- **Single port:** `MAX_BURST=4`, only port 3 ready continuously, `out_ready=1`. Expect `rd_en_sel=0x08` for 4 cycles, then 1 IDLE-granted cycle with the same port (`rr_ptr=4` wraps to 3). `vld_out` is high from cycle 2 onward with `grant_idx=3`.
- **Rotation:** ports 0, 2, 5 all ready, `MAX_BURST=2`. Grant sequence is 0,0,2,2,5,5,0,0. `dout_leaf` equals each port's packet 2 cycles after its grant.
- **Burst cut short:** port 1 drops `port_ready` after 2 grants in a burst. Expect one cycle with `rd_en_sel=0`, then port 2 (ready) granted, `rr_ptr=2`.
- **Backpressure:** `out_ready=0` for 3 cycles mid-burst. No grants during the stall; `burst_cnt` is preserved; the burst resumes and the owner receives the remaining grants. Exactly 2 packets appear after `out_ready` falls, none after.
- **Protocol error:** a port is granted but drives packet MSB=0. Expect `proto_err=1` at T+2, still set 10 cycles later, and cleared by `reset`.
- **Reset mid-burst:** assert `reset` at T+1 after a grant. At the next edge `vld_out=0`, `dout_leaf=0`, `rd_en_sel=0`. After release, the first grant goes to the lowest-index ready port.
